hs_rr_mux: RTL and testbench
============================

Name: hs_rr_mux

Overview:
- Parametrised N-channel send/ready handshake concentrator.
- Each source channel offers a DW-bit word. A round-robin arbiter grants one channel per cycle and writes the word, tagged with its channel id, into a DEPTH-entry FIFO.
- The consumer drains the FIFO with a valid/load handshake.
- Sits in the single-clock domain behind the CDC handshake stage, merging several producers onto one consumer path.

Parameters:
- NCH, 4, number of source channels (>=2)
- DW, 8, data width per channel
- DEPTH, 4, output FIFO entries (power of two, >=2)

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous reset, active-high
- adata  in  NCH*DW  channel i data in bits [i*DW +: DW]
- asend  in  NCH  channel i offers a word
- aready  out  NCH  channel i word accepted this cycle (one-hot or zero)
- dout  out  DW  FIFO head data
- dchan  out  clog2(NCH)  channel id of the head word
- bvalid  out  1  FIFO non-empty
- bload  in  1  consumer takes the head word
- level  out  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: clk is the only clock. rst is synchronous and active-high. While rst=1 at a rising edge, the FIFO empties, level=0, bvalid=0, aready=0, dout=0, dchan=0 and the RR pointer is 0. Reset asserted mid-transfer discards all stored words; no partial state survives.
- Grant:
  - aready is combinational from asend, the RR pointer and full.
  - When level==DEPTH, aready=0.
  - Otherwise grant the first asserted asend[i], searching from i=ptr upward with wrap NCH-1 -> 0.
- Push: a transfer on channel i occurs when asend[i] && aready[i]. The word {i, adata[i]} is written at the clock edge, and ptr becomes (i+1) mod NCH. With no transfer, ptr holds.
- Source rules: a source holds asend and its data stable until aready is seen. The block never drops or duplicates an offered word.
- Pop: occurs when bvalid && bload. The head advances at the edge. bload with bvalid=0 is ignored.
- Output timing: dout/dchan/bvalid are registered, so a word pushed into an empty FIFO appears on dout with bvalid=1 on the next cycle (latency 1). dout/dchan hold their value while bvalid=1 and bload=0.
- Simultaneous push and pop:
  - When not full, both occur and level is unchanged.
  - When full, no push (aready=0) but the pop occurs. The push is possible the following cycle; there is no same-cycle bypass.
- Pointers: read/write pointers are clog2(DEPTH) bits and wrap naturally. Full/empty is derived from level, which goes 0..DEPTH. level never exceeds DEPTH and never underflows.
- Fairness: with all asend held high and the consumer always loading, grants rotate 0,1,..,NCH-1,0. Each channel waits at most NCH-1 grants.
- Data when empty: dout is don't-care when bvalid=0. The implementation holds the last value.

Decomposition:
- Package hs_pkg:
  - clog2 constant function
  - localparam CW=clog2(NCH)
  - entry typedef {chan[CW], data[DW]}
- Sub-module hs_rr_arbiter:
  - NCH request vector, enable (=!full), pointer
  - outputs one-hot grant and encoded index
  - pointer register lives inside, updated on accepted grant
- Top holds FIFO storage, level counter and output registers.

Test Plan:
- Reset: drive asend=4'b1111 with rst=1 for 3 cycles -> aready=0, bvalid=0, level=0 throughout; release -> first grant to channel 0.
- Round-robin: NCH=4, adata ch0..3 = 8'h10,8'h21,8'h32,8'h43, all asend=1, bload=1 -> dout/dchan sequence 10/0, 21/1, 32/2, 43/3, 10/0, one per cycle after 1-cycle latency.
- Full/backpressure: bload=0, asend[2]=1 with data 8'hA5 -> 4 pushes, level=4, aready=0 on 5th cycle; set bload=1 for one cycle -> level 3, aready[2]=1 next cycle, level returns to 4.
- Simultaneous push/pop at level=2: asend[1]=1 (8'h5C) with bload=1 -> level stays 2, popped word is the oldest, 8'h5C appears after two further pops.
- Reset mid-operation: level=3, then rst=1 for one cycle -> next cycle level=0, bvalid=0, ptr=0; old words never appear on dout.
- Sparse requests: only asend[3] and asend[1] high, ptr=2 -> grant order 3,1,3,1; channels 0 and 2 never granted; no lost words (count pushes == pops).

Source files
------------

// File: rtl/hs_rr_mux_pkg.sv
// Shared helpers and default sizing for the round-robin handshake concentrator.
// Holds the clog2 helper, the default geometry and the stored-entry layout.
package hs_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int NCH_DEF   = 4;
  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 4;
  localparam int CW        = clog2(NCH_DEF);

  // One FIFO slot at the default geometry: source channel id plus its data word.
  typedef struct packed {
    logic [CW-1:0]     chan;
    logic [DW_DEF-1:0] data;
  } entry_t;

endpackage

// File: rtl/hs_rr_mux_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer, wrapping.
// The pointer moves to one past the granted channel whenever a grant is issued.
module hs_rr_arbiter
  import hs_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           req,
  input  logic                     en,
  output logic [NCH-1:0]           gnt,
  output logic [clog2(NCH)-1:0]    idx
);

  localparam int AW = clog2(NCH);

  logic [AW-1:0] ptr;
  logic          found;
  int            pos;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < NCH; k++) begin
      pos = (int'(ptr) + k) % NCH;
      if (en && !found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = AW'(pos);
      end
    end
  end

  // A grant is only raised for an active request, so a grant is always a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (int'(idx) == NCH - 1) ? '0 : idx + AW'(1);
    end
  end

endmodule

// File: rtl/hs_rr_mux.sv
// N-channel handshake concentrator: round-robin grant into a DEPTH-entry FIFO
// whose head word and channel id are presented on registered outputs.
module hs_rr_mux
  import hs_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NCH*DW-1:0]           adata,
  input  logic [NCH-1:0]              asend,
  output logic [NCH-1:0]              aready,
  output logic [DW-1:0]               dout,
  output logic [clog2(NCH)-1:0]       dchan,
  output logic                        bvalid,
  input  logic                        bload,
  output logic [clog2(DEPTH):0]       level
);

  localparam int CWL = clog2(NCH);
  localparam int AW  = clog2(DEPTH);
  localparam int LW  = AW + 1;

  typedef struct packed {
    logic [CWL-1:0] chan;
    logic [DW-1:0]  data;
  } fifo_entry_t;

  // Handshakes: a source word moves when asend[i] && aready[i] at a rising edge;
  // the head word leaves when bvalid && bload at a rising edge. Neither side
  // may withdraw an offer, and neither ready/load has any effect without valid.

  fifo_entry_t    mem [DEPTH];
  fifo_entry_t    wr_entry;
  fifo_entry_t    head;
  fifo_entry_t    head_nx;
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic [AW-1:0]  rptr_nx;
  logic [LW-1:0]  level_nx;
  logic [LW-1:0]  remain;
  logic [NCH-1:0] gnt;
  logic [CWL-1:0] gnt_idx;
  logic           full;
  logic           push;
  logic           pop;

  assign full = (level == LW'(DEPTH));

  hs_rr_arbiter #(.NCH(NCH)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (asend),
    .en  (!full && !rst),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign aready   = gnt;
  assign push     = |gnt;
  assign pop      = bvalid && bload;
  assign wr_entry = '{chan: gnt_idx, data: adata[int'(gnt_idx)*DW +: DW]};

  // The head register must look one write ahead: when the FIFO is about to hold
  // only the word being written, that word becomes the head with no extra cycle.
  always_comb begin
    level_nx = level;
    if (push && !pop)      level_nx = level + LW'(1);
    else if (!push && pop) level_nx = level - LW'(1);
    rptr_nx = pop ? rptr + AW'(1) : rptr;
    remain  = pop ? level - LW'(1) : level;
    head_nx = head;
    if (level_nx != '0) begin
      head_nx = (remain == '0) ? wr_entry : mem[rptr_nx];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      level  <= '0;
      bvalid <= 1'b0;
      head   <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      rptr   <= rptr_nx;
      level  <= level_nx;
      bvalid <= (level_nx != '0);
      head   <= head_nx;
    end
  end

  assign dout  = head.data;
  assign dchan = head.chan;

endmodule

// File: tb/tb_hs_rr_mux.sv
// Directed table-driven bench for hs_rr_mux at NCH=4, DW=8, DEPTH=4, with a
// queue scoreboard following every accepted and delivered word.
module tb_hs_rr_mux;

  logic        clk;
  logic        rst;
  logic [31:0] adata;
  logic [3:0]  asend;
  logic [3:0]  aready;
  logic [7:0]  dout;
  logic [1:0]  dchan;
  logic        bvalid;
  logic        bload;
  logic [2:0]  level;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  asend;
    logic [31:0] adata;
    logic        bload;
    logic [3:0]  ex_rdy;
    logic        ex_vld;
    logic [2:0]  ex_lvl;
    logic [7:0]  ex_d;
    logic [1:0]  ex_c;
    logic        chk_d;
  } vec_t;

  vec_t vt[$];
  logic [9:0] exp_q[$];

  hs_rr_mux #(.NCH(4), .DW(8), .DEPTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .adata  (adata),
    .asend  (asend),
    .aready (aready),
    .dout   (dout),
    .dchan  (dchan),
    .bvalid (bvalid),
    .bload  (bload),
    .level  (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic add(input logic r, input logic [3:0] s, input logic [31:0] d, input logic l,
                     input logic [3:0] er, input logic ev, input logic [2:0] el,
                     input logic [7:0] ed, input logic [1:0] ec, input logic cd);
    vec_t v;
    v.rst = r; v.asend = s; v.adata = d; v.bload = l;
    v.ex_rdy = er; v.ex_vld = ev; v.ex_lvl = el; v.ex_d = ed; v.ex_c = ec; v.chk_d = cd;
    vt.push_back(v);
  endtask

  // Scoreboard: record accepted words, match delivered words in order.
  task automatic score();
    logic [9:0] e;
    if (bvalid && bload) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_word", {22'd0, dchan, dout}, {22'd0, e});
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (asend[i] && aready[i]) exp_q.push_back({i[1:0], adata[i*8 +: 8]});
    end
  endtask

  initial begin
    rst = 1'b1; asend = '0; adata = '0; bload = 1'b0;
    // rst asend adata bload | aready bvalid level dout dchan chk_d
    add(1, 4'hF, 32'h43322110, 0, 4'h0, 0, 0, 8'h00, 0, 1);
    add(1, 4'hF, 32'h43322110, 0, 4'h0, 0, 0, 8'h00, 0, 1);
    add(1, 4'hF, 32'h43322110, 0, 4'h0, 0, 0, 8'h00, 0, 1);
    add(0, 4'hF, 32'h43322110, 1, 4'h1, 0, 0, 8'h00, 0, 0);
    add(0, 4'hF, 32'h43322110, 1, 4'h2, 1, 1, 8'h10, 0, 1);
    add(0, 4'hF, 32'h43322110, 1, 4'h4, 1, 1, 8'h21, 1, 1);
    add(0, 4'hF, 32'h43322110, 1, 4'h8, 1, 1, 8'h32, 2, 1);
    add(0, 4'hF, 32'h43322110, 1, 4'h1, 1, 1, 8'h43, 3, 1);
    add(0, 4'hF, 32'h43322110, 1, 4'h2, 1, 1, 8'h10, 0, 1);
    add(0, 4'h0, 32'h00000000, 1, 4'h0, 1, 1, 8'h21, 1, 1);
    add(0, 4'h4, 32'h00A50000, 0, 4'h4, 0, 0, 8'h00, 0, 0);
    add(0, 4'h4, 32'h00A60000, 0, 4'h4, 1, 1, 8'hA5, 2, 1);
    add(0, 4'h4, 32'h00A70000, 0, 4'h4, 1, 2, 8'hA5, 2, 1);
    add(0, 4'h4, 32'h00A80000, 0, 4'h4, 1, 3, 8'hA5, 2, 1);
    add(0, 4'h4, 32'h00A90000, 0, 4'h0, 1, 4, 8'hA5, 2, 1);
    add(0, 4'h4, 32'h00A90000, 1, 4'h0, 1, 4, 8'hA5, 2, 1);
    add(0, 4'h4, 32'h00A90000, 0, 4'h4, 1, 3, 8'hA6, 2, 1);
    add(0, 4'h0, 32'h00000000, 0, 4'h0, 1, 4, 8'hA6, 2, 1);
    add(0, 4'h0, 32'h00000000, 1, 4'h0, 1, 4, 8'hA6, 2, 1);
    add(0, 4'h0, 32'h00000000, 1, 4'h0, 1, 3, 8'hA7, 2, 1);
    add(0, 4'h2, 32'h00005C00, 1, 4'h2, 1, 2, 8'hA8, 2, 1);
    add(0, 4'h0, 32'h00000000, 1, 4'h0, 1, 2, 8'hA9, 2, 1);
    add(0, 4'h0, 32'h00000000, 1, 4'h0, 1, 1, 8'h5C, 1, 1);
    add(0, 4'h0, 32'h00000000, 1, 4'h0, 0, 0, 8'h00, 0, 0);
    add(0, 4'h1, 32'h000000B0, 0, 4'h1, 0, 0, 8'h00, 0, 0);
    add(0, 4'h1, 32'h000000B1, 0, 4'h1, 1, 1, 8'hB0, 0, 1);
    add(0, 4'h1, 32'h000000B2, 0, 4'h1, 1, 2, 8'hB0, 0, 1);
    add(0, 4'h0, 32'h00000000, 0, 4'h0, 1, 3, 8'hB0, 0, 1);
    add(1, 4'hF, 32'h43322110, 1, 4'h0, 1, 3, 8'hB0, 0, 1);
    add(0, 4'h0, 32'h00000000, 1, 4'h0, 0, 0, 8'h00, 0, 1);
    add(0, 4'h2, 32'h0000C100, 1, 4'h2, 0, 0, 8'h00, 0, 0);
    add(0, 4'hA, 32'hD300C200, 1, 4'h8, 1, 1, 8'hC1, 1, 1);
    add(0, 4'hA, 32'hD400C200, 1, 4'h2, 1, 1, 8'hD3, 3, 1);
    add(0, 4'hA, 32'hD400C300, 1, 4'h8, 1, 1, 8'hC2, 1, 1);
    add(0, 4'hA, 32'hD500C300, 1, 4'h2, 1, 1, 8'hD4, 3, 1);
    add(0, 4'h0, 32'h00000000, 1, 4'h0, 1, 1, 8'hC3, 1, 1);
    add(0, 4'h0, 32'h00000000, 0, 4'h0, 0, 0, 8'h00, 0, 0);

    repeat (2) @(posedge clk);
    foreach (vt[n]) begin
      @(negedge clk);
      rst = vt[n].rst; asend = vt[n].asend; adata = vt[n].adata; bload = vt[n].bload;
      #1;
      chk($sformatf("v%0d_aready", n), 32'(aready), 32'(vt[n].ex_rdy));
      chk($sformatf("v%0d_bvalid", n), 32'(bvalid), 32'(vt[n].ex_vld));
      chk($sformatf("v%0d_level", n), 32'(level), 32'(vt[n].ex_lvl));
      if (vt[n].chk_d) begin
        chk($sformatf("v%0d_dout", n), 32'(dout), 32'(vt[n].ex_d));
        chk($sformatf("v%0d_dchan", n), 32'(dchan), 32'(vt[n].ex_c));
      end
      if (rst) exp_q.delete();
      else score();
    end
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    // Fairness: all channels requesting, consumer always loading, from reset.
    @(negedge clk);
    rst = 1'b1; asend = 4'hF; adata = 32'h43322110; bload = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("fair%0d_aready", k), 32'(aready), 32'(1 << (k % 4)));
      if (k >= 1) begin
        chk($sformatf("fair%0d_bvalid", k), 32'(bvalid), 32'd1);
        chk($sformatf("fair%0d_dchan", k), 32'(dchan), 32'((k - 1) % 4));
      end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
